// File: rtl/packet_rx_fifo.sv
// rtl/packet_rx_fifo.sv - receive FIFO for a no-backpressure beat stream, with drop flag and counter
module packet_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              valid_in,
    output logic [7:0]        data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clear_overflow,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              pop;
    logic              push;
    logic              drop;

    // Outputs derive from the registered level, so reset clears them without a clock edge.
    assign valid_out = (level != '0);
    assign data_out  = valid_out ? mem[rptr] : 8'h00;

    assign pop  = valid_out & ready_in;
    assign push = valid_in & ((level < FULL_LEVEL) | pop);
    assign drop = valid_in & ~push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data_in;
        end
    end

    // A drop in the same cycle as a clear wins and counts as the first new drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= 8'h01;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'h01;
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end
    end

endmodule

// File: tb/tb_packet_rx_fifo.sv
// tb/tb_packet_rx_fifo.sv - directed and random checks of packet_rx_fifo against a queue model
module tb_packet_rx_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in = 1'b0;
    logic [3:0] level;
    logic       overflow;
    logic       clear_overflow = 1'b0;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_cnt = 0;
    bit         chk_en = 1'b0;

    packet_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit r, input bit c);
        bit do_pop;
        bit do_push;
        bit do_drop;
        logic [7:0] discard;
        do_pop  = (m_q.size() > 0) && r;
        do_push = v && ((m_q.size() < DEPTH) || do_pop);
        do_drop = v && !do_push;
        if (do_pop) discard = m_q.pop_front();
        if (do_push) m_q.push_back(d);
        if (do_drop) begin
            m_ovf = 1'b1;
            m_cnt = c ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
        end else if (c) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, settle 1 time unit.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c);
        valid_in       = v;
        data_in        = d;
        ready_in       = r;
        clear_overflow = c;
        @(posedge clk);
        model_edge(v, d, r, c);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model_valid_out", int'(valid_out), int'(m_q.size() != 0));
            chk("model_data_out", int'(data_out), (m_q.size() != 0) ? int'(m_q[0]) : 0);
            chk("model_level", int'(level), m_q.size());
            chk("model_overflow", int'(overflow), int'(m_ovf));
            chk("model_drop_count", int'(drop_count), m_cnt);
        end
    end

    initial begin
        logic [7:0] drain_exp [8];
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'(i + 1);
        drain_exp[7] = 8'hBB;

        #1;
        chk("reset_valid_out", int'(valid_out), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_drop_count", int'(drop_count), 0);
        #2;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        step(0, 8'h00, 0, 0);

        // Streaming with ready held high: no bypass, one-cycle latency, level stays at 1
        valid_in = 1'b1; data_in = 8'h11; ready_in = 1'b1;
        #1;
        chk("no_bypass_valid_out", int'(valid_out), 0);
        step(1, 8'h11, 1, 0);
        chk("stream_d0", int'(data_out), 8'h11);
        chk("stream_lvl0", int'(level), 1);
        step(1, 8'h22, 1, 0);
        chk("stream_d1", int'(data_out), 8'h22);
        chk("stream_lvl1", int'(level), 1);
        step(1, 8'h33, 1, 0);
        chk("stream_d2", int'(data_out), 8'h33);
        chk("stream_lvl2", int'(level), 1);
        step(0, 8'h00, 1, 0);
        chk("stream_empty", int'(valid_out), 0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
        chk("full_level", int'(level), 8);
        chk("full_valid_out", int'(valid_out), 1);
        chk("full_head", int'(data_out), 8'h00);
        step(1, 8'hAA, 0, 0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(drop_count), 1);
        chk("ovf_level", int'(level), 8);

        // Push and pop together while full: no drop
        step(1, 8'hBB, 1, 0);
        chk("fullpp_level", int'(level), 8);
        chk("fullpp_head", int'(data_out), 8'h01);
        chk("fullpp_count", int'(drop_count), 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", int'(data_out), int'(drain_exp[i]));
            step(0, 8'h00, 1, 0);
        end
        chk("drain_empty_level", int'(level), 0);

        // Saturation of the drop counter, then clear racing a drop
        for (int i = 0; i < DEPTH; i++) step(1, 8'h50 + 8'(i), 0, 0);
        for (int i = 0; i < 300; i++) step(1, 8'hEE, 0, 0);
        chk("sat_count", int'(drop_count), 255);
        chk("sat_level", int'(level), 8);
        step(1, 8'hEE, 0, 1);
        chk("clr_drop_flag", int'(overflow), 1);
        chk("clr_drop_count", int'(drop_count), 1);
        step(0, 8'h00, 0, 1);
        chk("clr_flag", int'(overflow), 0);
        chk("clr_count", int'(drop_count), 0);
        chk("clr_head", int'(data_out), 8'h50);

        // Asynchronous reset mid-stream with the FIFO full and a drop recorded
        step(1, 8'hCC, 0, 0);
        chk("pre_rst_flag", int'(overflow), 1);
        valid_in = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid_out", int'(valid_out), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_overflow", int'(overflow), 0);
        chk("arst_drop_count", int'(drop_count), 0);
        chk("arst_data_out", int'(data_out), 0);
        #1;
        rst_n = 1'b1;
        step(0, 8'h00, 0, 0);
        chk("post_rst_level", int'(level), 0);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 199) == 0));
        end
        step(0, 8'h00, 0, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
